multi_itype_detector: RTL and testbench
=======================================

MULTI_ITYPE_DETECTOR -- requirements
Module: multi_itype_detector

Interface
REQ-001 Parameter NRET, default 2: number of commit lanes classified per cycle; legal range 1..4.
REQ-002 Parameter XLEN, default mure_pkg::XLEN: instruction address width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 valid_i  input  NRET  per-lane retired-instruction valid; lane 0 oldest; asserted lanes packed from lane 0.
REQ-006 iaddr_i  input  NRET x XLEN  per-lane instruction address.
REQ-007 inst_data_i  input  NRET x 32  per-lane instruction word; compressed instructions in bits [15:0].
REQ-008 compressed_i, exception_i, interrupt_i, eret_i  input  NRET each  per-lane attributes.
REQ-009 flush_i  input  1  emit the held instruction without waiting for a successor.
REQ-010 valid_o  output  NRET  per-lane classified-instruction valid, packed from lane 0.
REQ-011 iaddr_o  output  NRET x XLEN  address of the classified instruction.
REQ-012 itype_o  output  NRET x itype_e  per-lane instruction type.

Function
REQ-013 itype_e encoding, 3 bits: 0 STD, 1 EXC, 2 INT, 3 ERET, 4 NT_BR, 5 T_BR, 6 UNINF_JMP, 7 reserved and never produced.
REQ-014 Priority: exception > interrupt > eret > branch > uninferable jump > STD.
REQ-015 Branch: opcode 1100011, or compressed quadrant 01 with funct3 110/111.
REQ-016 Uninferable jump: opcode 1100111 (jalr), or compressed quadrant 10 with funct4 100x, rs2=0 and rs1!=0.
REQ-017 A branch is T_BR when next_addr != addr + (compressed ? 2 : 4), computed modulo 2^XLEN; otherwise it is NT_BR.
REQ-018 Window: the youngest valid instruction of each cycle is held in a pending register and is classified only when its successor arrives.
REQ-019 With k valid input lanes and pending valid, output lane 0 = pending classified against input lane 0; output lane j (1..k-1) = input lane j-1 classified against input lane j; input lane k-1 becomes the new pending entry.
REQ-020 With pending empty, such as after reset, the first input lane produces no output; the cycle emits k-1 lanes.
REQ-021 Outputs are registered: latency is 1 cycle from the cycle in which the successor is presented.
REQ-022 k=0 and flush_i low: valid_o all 0, and pending is retained unchanged.
REQ-023 flush_i with k=0: pending is emitted on lane 0 next cycle with an absent successor, so a branch is NT_BR; pending is cleared.
REQ-024 flush_i with k>0: normal REQ-019 output, and the youngest input is also emitted in lane k instead of being held; NRET+1 outputs is impossible, so flush_i with k=NRET holds it, and flush is re-applied next cycle by the source.
REQ-025 Non-packed valid_i is illegal; the behaviour is undefined and is flagged by a simulation assertion.
REQ-026 Output lanes whose valid_o=0 drive iaddr_o=0 and itype_o=STD.

Reset
REQ-027 rst_ni low at a clock edge: valid_o=0, iaddr_o=0, itype_o=STD, pending cleared; inputs in that cycle are discarded.
REQ-028 Reset asserted mid-stream drops the pending instruction without emitting it.

Structure
REQ-029 mure_pkg holds itype_e, XLEN, and the opcode/funct constants.
REQ-030 One combinational sub-module, itype_classifier, maps one instruction plus its next address and a next-valid flag to itype_e; it is instantiated NRET times.
REQ-031 The top level contains only the pending register, the lane steering, the flush logic and the output registers.

Verification
REQ-032 NRET=2; beq at 0x100 (4 B) then 0x104 in one cycle -> next cycle lane 0 = {0x100, NT_BR}, and 0x104 is pending.
REQ-033 Pending beq at 0x200; next cycle lane 0 = 0x300 -> output {0x200, T_BR}; with lane 1 = 0x302 also valid, output lane 1 = {0x300, classified}.
REQ-034 Pending c.jr at 0x40 with flush_i=1 and no valid inputs -> next cycle lane 0 = {0x40, UNINF_JMP}, valid_o=01, pending empty.
REQ-035 A lane with exception_i=1 on a beq whose successor makes it taken -> EXC, which overrides T_BR.
REQ-036 rst_ni low while pending is valid -> next cycle valid_o=0; the following input lane produces no output (REQ-020).
REQ-037 Address 0xFFFF_FFFC beq with next 0x0000_0000 (XLEN=32) -> NT_BR (wrap-around).

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types and decode constants for the retired-instruction type detector.
package mure_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ITYPE_STD       = 3'd0,
    ITYPE_EXC       = 3'd1,
    ITYPE_INT       = 3'd2,
    ITYPE_ERET      = 3'd3,
    ITYPE_NT_BR     = 3'd4,
    ITYPE_T_BR      = 3'd5,
    ITYPE_UNINF_JMP = 3'd6
  } itype_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [1:0] CQ_BRANCH  = 2'b01;
  localparam logic [1:0] CQ_JR      = 2'b10;
  localparam logic [2:0] CF3_BEQZ   = 3'b110;
  localparam logic [2:0] CF3_BNEZ   = 3'b111;
  // c.jr / c.jalr share funct4 100x; bit 12 only selects link vs no link
  localparam logic [2:0] CF4_JR_HI  = 3'b100;

  typedef struct packed {
    logic [31:0] inst;
    logic        compressed;
    logic        exception;
    logic        interrupt;
    logic        eret;
  } inst_attr_t;

endpackage

// File: rtl/itype_classifier.sv
// Combinational classifier: one retired instruction plus its successor address
// to an itype_e, with exception > interrupt > eret > branch > jump > STD.
module itype_classifier
  import mure_pkg::*;
#(
  parameter int XLEN = mure_pkg::XLEN
) (
  input  logic [XLEN-1:0] iaddr_i,
  input  inst_attr_t      attr_i,
  input  logic [XLEN-1:0] next_addr_i,
  input  logic            next_valid_i,
  output itype_e          itype_o
);

  logic            w_is_branch;
  logic            w_is_ujmp;
  logic            w_taken;
  logic [XLEN-1:0] w_seq_addr;
  logic            w_unused_hi;

  assign w_unused_hi = ^attr_i.inst[31:16];

  always_comb begin
    w_is_branch = 1'b0;
    w_is_ujmp   = 1'b0;
    if (attr_i.compressed) begin
      w_is_branch = (attr_i.inst[1:0] == CQ_BRANCH) &&
                    ((attr_i.inst[15:13] == CF3_BEQZ) || (attr_i.inst[15:13] == CF3_BNEZ));
      w_is_ujmp   = (attr_i.inst[1:0] == CQ_JR) && (attr_i.inst[15:13] == CF4_JR_HI) &&
                    (attr_i.inst[6:2] == 5'd0) && (attr_i.inst[11:7] != 5'd0);
    end else begin
      w_is_branch = (attr_i.inst[6:0] == OPC_BRANCH);
      w_is_ujmp   = (attr_i.inst[6:0] == OPC_JALR);
    end
  end

  // Without a successor there is no evidence of a redirect, so a branch reads as not taken
  assign w_seq_addr = iaddr_i + (attr_i.compressed ? XLEN'(2) : XLEN'(4));
  assign w_taken    = next_valid_i && (next_addr_i != w_seq_addr);

  always_comb begin
    itype_o = ITYPE_STD;
    if (attr_i.exception)      itype_o = ITYPE_EXC;
    else if (attr_i.interrupt) itype_o = ITYPE_INT;
    else if (attr_i.eret)      itype_o = ITYPE_ERET;
    else if (w_is_branch)      itype_o = w_taken ? ITYPE_T_BR : ITYPE_NT_BR;
    else if (w_is_ujmp)        itype_o = ITYPE_UNINF_JMP;
  end

endmodule

// File: rtl/multi_itype_detector.sv
// Multi-lane instruction-type detector: holds the youngest retired instruction
// until its successor (or a flush) arrives, then classifies and registers it.
module multi_itype_detector
  import mure_pkg::*;
#(
  parameter int NRET = 2,
  parameter int XLEN = mure_pkg::XLEN
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NRET-1:0]            valid_i,
  input  logic [NRET-1:0][XLEN-1:0]  iaddr_i,
  input  logic [NRET-1:0][31:0]      inst_data_i,
  input  logic [NRET-1:0]            compressed_i,
  input  logic [NRET-1:0]            exception_i,
  input  logic [NRET-1:0]            interrupt_i,
  input  logic [NRET-1:0]            eret_i,
  input  logic                       flush_i,
  output logic [NRET-1:0]            valid_o,
  output logic [NRET-1:0][XLEN-1:0]  iaddr_o,
  output itype_e [NRET-1:0]          itype_o
);

  logic                      r_pend_v;
  logic [XLEN-1:0]           r_pend_addr;
  inst_attr_t                r_pend_attr;
  logic [NRET-1:0]           r_valid;
  logic [NRET-1:0][XLEN-1:0] r_iaddr;
  itype_e [NRET-1:0]         r_itype;

  logic [2:0]      w_k;
  logic [2:0]      w_n;
  logic [XLEN-1:0] w_seq_addr [NRET:0];
  inst_attr_t      w_seq_attr [NRET:0];
  logic [NRET-1:0] w_next_v;
  logic [NRET-1:0] w_emit;
  itype_e          w_itype    [NRET-1:0];
  logic            w_flush_out;
  logic            w_pend_v_nxt;
  logic [XLEN-1:0] w_pend_addr_nxt;
  inst_attr_t      w_pend_attr_nxt;
  logic [NRET-1:0] w_valid_p1;

  // Sequence = pending (if any) followed by the packed input lanes, oldest first
  always_comb begin
    w_k = '0;
    for (int i = 0; i < NRET; i++) w_k = w_k + 3'(valid_i[i]);
    w_n = w_k + 3'(r_pend_v);
    for (int i = 0; i <= NRET; i++) begin
      w_seq_addr[i] = '0;
      w_seq_attr[i] = '0;
    end
    if (r_pend_v) begin
      w_seq_addr[0] = r_pend_addr;
      w_seq_attr[0] = r_pend_attr;
    end
    for (int i = 0; i < NRET; i++) begin
      w_seq_addr[i + int'(r_pend_v)] = iaddr_i[i];
      w_seq_attr[i + int'(r_pend_v)] = '{inst_data_i[i], compressed_i[i], exception_i[i],
                                         interrupt_i[i], eret_i[i]};
    end
    for (int j = 0; j < NRET; j++) begin
      w_next_v[j] = (j + 1) < int'(w_n);
      w_emit[j]   = w_next_v[j] || (flush_i && ((j + 1) == int'(w_n)));
    end
    w_flush_out = flush_i && (w_n != 3'd0) && (int'(w_n) <= NRET);
  end

  always_comb begin
    w_pend_v_nxt    = r_pend_v;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_attr_nxt = r_pend_attr;
    if (w_flush_out) begin
      w_pend_v_nxt = 1'b0;
    end else begin
      for (int i = 0; i < NRET; i++) begin
        if (valid_i[i]) begin
          w_pend_v_nxt    = 1'b1;
          w_pend_addr_nxt = iaddr_i[i];
          w_pend_attr_nxt = '{inst_data_i[i], compressed_i[i], exception_i[i],
                              interrupt_i[i], eret_i[i]};
        end
      end
    end
  end

  for (genvar j = 0; j < NRET; j++) begin : g_cls
    itype_classifier #(.XLEN(XLEN)) u_cls (
      .iaddr_i     (w_seq_addr[j]),
      .attr_i      (w_seq_attr[j]),
      .next_addr_i (w_seq_addr[j+1]),
      .next_valid_i(w_next_v[j]),
      .itype_o     (w_itype[j])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_attr <= '0;
      r_valid     <= '0;
      r_iaddr     <= '0;
      for (int j = 0; j < NRET; j++) r_itype[j] <= ITYPE_STD;
    end else begin
      r_pend_v    <= w_pend_v_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_attr <= w_pend_attr_nxt;
      r_valid     <= w_emit;
      for (int j = 0; j < NRET; j++) begin
        r_iaddr[j] <= w_emit[j] ? w_seq_addr[j] : '0;
        r_itype[j] <= w_emit[j] ? w_itype[j] : ITYPE_STD;
      end
    end
  end

  assign valid_o = r_valid;
  assign iaddr_o = r_iaddr;
  assign itype_o = r_itype;

  // Valid lanes must be packed from lane 0
  assign w_valid_p1 = valid_i + NRET'(1);
  always @(posedge clk_i) begin
    if (rst_ni) assert ((valid_i & w_valid_p1) == '0);
  end

endmodule

// File: tb/tb_multi_itype_detector.sv
// Scoreboard bench for multi_itype_detector: directed cases then random traffic.
module tb_multi_itype_detector;
  import mure_pkg::*;

  localparam int NRET = 2;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_ni;
  logic [NRET-1:0]           valid_i;
  logic [NRET-1:0][XLEN-1:0] iaddr_i;
  logic [NRET-1:0][31:0]     inst_data_i;
  logic [NRET-1:0]           compressed_i, exception_i, interrupt_i, eret_i;
  logic                      flush_i;
  logic [NRET-1:0]           valid_o;
  logic [NRET-1:0][XLEN-1:0] iaddr_o;
  itype_e [NRET-1:0]         itype_o;

  multi_itype_detector #(.NRET(NRET), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .iaddr_i(iaddr_i),
    .inst_data_i(inst_data_i), .compressed_i(compressed_i), .exception_i(exception_i),
    .interrupt_i(interrupt_i), .eret_i(eret_i), .flush_i(flush_i),
    .valid_o(valid_o), .iaddr_o(iaddr_o), .itype_o(itype_o)
  );

  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] JALR  = 32'h0000_8067;
  localparam logic [31:0] ADD   = 32'h0000_0033;
  localparam logic [31:0] CJR   = 32'h0000_8082;
  localparam logic [31:0] CBEQZ = 32'h0000_C001;
  localparam logic [31:0] CMV   = 32'h0000_8086;
  localparam logic [31:0] CNOP  = 32'h0000_0001;

  typedef struct packed {
    logic [NRET-1:0]           v;
    logic [NRET-1:0][XLEN-1:0] a;
    logic [NRET-1:0][2:0]      t;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic        m_pv = 1'b0;
  logic [31:0] m_pa, m_pd;
  logic        m_pc, m_pe, m_pi, m_pr;

  logic [31:0] tbl_d [7];
  logic        tbl_c [7];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] mdl_type(input logic [31:0] d, input logic c, input logic exc,
                                          input logic intr, input logic er, input logic [31:0] a,
                                          input logic [31:0] na, input logic nv);
    logic br, uj;
    logic [31:0] seq;
    if (exc)  return 3'd1;
    if (intr) return 3'd2;
    if (er)   return 3'd3;
    br  = c ? (d[1:0] == 2'b01 && d[15:14] == 2'b11) : (d[6:0] == 7'h63);
    uj  = c ? (d[1:0] == 2'b10 && d[15:13] == 3'b100 && d[6:2] == 5'd0 && d[11:7] != 5'd0)
            : (d[6:0] == 7'h67);
    seq = a + (c ? 32'd2 : 32'd4);
    if (br) return (nv && na != seq) ? 3'd5 : 3'd4;
    if (uj) return 3'd6;
    return 3'd0;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk($sformatf("c%0d valid", cyc), 64'(valid_o), 64'(e.v));
    for (int j = 0; j < NRET; j++) begin
      chk($sformatf("c%0d l%0d addr", cyc, j), 64'(iaddr_o[j]), 64'(e.a[j]));
      chk($sformatf("c%0d l%0d type", cyc, j), 64'(itype_o[j]), 64'(e.t[j]));
    end
  endtask

  // Drives one cycle of inputs and pushes the model's prediction for the next cycle
  task automatic drive(input logic rst, input logic fl, input logic [1:0] v,
                       input logic [1:0][31:0] a, input logic [1:0][31:0] d,
                       input logic [1:0] c, input logic [1:0] exc,
                       input logic [1:0] intr, input logic [1:0] er);
    exp_t        e;
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    logic        ec [3], ee [3], ei [3], err [3];
    int          n, oc;
    rst_ni = rst; flush_i = fl; valid_i = v; iaddr_i = a; inst_data_i = d;
    compressed_i = c; exception_i = exc; interrupt_i = intr; eret_i = er;
    e = '0;
    n = 0;
    oc = 0;
    if (!rst) begin
      m_pv = 1'b0;
    end else begin
      if (m_pv) begin
        ea[0] = m_pa; ed[0] = m_pd; ec[0] = m_pc; ee[0] = m_pe; ei[0] = m_pi; err[0] = m_pr;
        n = 1;
      end
      for (int i = 0; i < NRET; i++) begin
        if (v[i]) begin
          ea[n] = a[i]; ed[n] = d[i]; ec[n] = c[i]; ee[n] = exc[i]; ei[n] = intr[i]; err[n] = er[i];
          n++;
        end
      end
      for (int i = 0; i + 1 < n; i++) begin
        e.v[oc] = 1'b1;
        e.a[oc] = ea[i];
        e.t[oc] = mdl_type(ed[i], ec[i], ee[i], ei[i], err[i], ea[i], ea[i+1], 1'b1);
        oc++;
      end
      if (n > 0) begin
        if (fl && oc < NRET) begin
          e.v[oc] = 1'b1;
          e.a[oc] = ea[n-1];
          e.t[oc] = mdl_type(ed[n-1], ec[n-1], ee[n-1], ei[n-1], err[n-1], ea[n-1], 32'd0, 1'b0);
          m_pv = 1'b0;
        end else begin
          m_pv = 1'b1;
          m_pa = ea[n-1]; m_pd = ed[n-1]; m_pc = ec[n-1];
          m_pe = ee[n-1]; m_pi = ei[n-1]; m_pr = err[n-1];
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic fl, input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] d0, input logic c0,
                      input logic [31:0] a1, input logic [31:0] d1, input logic c1,
                      input logic [1:0] exc, input logic [1:0] intr, input logic [1:0] er);
    @(negedge clk);
    cyc++;
    check_out();
    drive(rst, fl, v, {a1, a0}, {d1, d0}, {c1, c0}, exc, intr, er);
  endtask

  initial begin
    logic [1:0][31:0] ra, rd;
    logic [1:0]       rc, rv, rexc, rint, rer;
    logic [31:0]      pc;
    int               k, idx;
    tbl_d[0] = BEQ;  tbl_c[0] = 1'b0;
    tbl_d[1] = JALR; tbl_c[1] = 1'b0;
    tbl_d[2] = ADD;  tbl_c[2] = 1'b0;
    tbl_d[3] = CJR;  tbl_c[3] = 1'b1;
    tbl_d[4] = CBEQZ; tbl_c[4] = 1'b1;
    tbl_d[5] = CMV;  tbl_c[5] = 1'b1;
    tbl_d[6] = CNOP; tbl_c[6] = 1'b1;

    drive(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0);
    step(1'b0, 1'b0, 2'b11, 32'h50, BEQ, 0, 32'h54, BEQ, 0, 2'b00, 2'b00, 2'b00);
    // beq pair: first classified NT_BR, second held
    step(1, 0, 2'b11, 32'h100, BEQ, 0, 32'h104, BEQ, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'h108, CBEQZ, 1, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'h200, BEQ, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b11, 32'h300, JALR, 0, 32'h302, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b00, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'h40, CJR, 1, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    // flush with no inputs emits the held c.jr
    step(1, 1, 2'b00, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'h500, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b11, 32'h504, BEQ, 0, 32'h600, ADD, 0, 2'b01, 2'b00, 2'b00);
    step(1, 0, 2'b11, 32'h604, BEQ, 0, 32'h700, BEQ, 0, 2'b00, 2'b01, 2'b10);
    step(1, 0, 2'b01, 32'h800, CMV, 1, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 1, 2'b01, 32'h802, CBEQZ, 1, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 1, 2'b11, 32'h900, BEQ, 0, 32'h904, CBEQZ, 1, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'hA00, BEQ, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    // flush with all lanes busy must still hold the youngest
    step(1, 1, 2'b11, 32'hA10, ADD, 0, 32'hA14, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 1, 2'b00, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'hB00, BEQ, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b01, 32'hC00, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'hD00, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    // address wrap-around is sequential, so not taken
    step(1, 0, 2'b01, 32'hFFFF_FFFC, BEQ, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 0, 2'b01, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);
    step(1, 1, 2'b00, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);

    pc = 32'h1000;
    for (int s = 0; s < 80; s++) begin
      k  = $urandom_range(0, 2);
      rv = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
      for (int l = 0; l < NRET; l++) begin
        idx   = $urandom_range(0, 6);
        rd[l] = tbl_d[idx];
        rc[l] = tbl_c[idx];
        if ($urandom_range(0, 3) == 0) pc = $urandom & 32'hFFFF_FFFE;
        ra[l] = pc;
        pc    = pc + (rc[l] ? 32'd2 : 32'd4);
        rexc[l] = ($urandom_range(0, 9) == 0);
        rint[l] = ($urandom_range(0, 9) == 0);
        rer[l]  = ($urandom_range(0, 9) == 0);
      end
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0), rv,
           ra[0], rd[0], rc[0], ra[1], rd[1], rc[1], rexc, rint, rer);
    end
    for (int s = 0; s < 3; s++)
      step(1, 1, 2'b00, 32'h0, ADD, 0, 32'h0, ADD, 0, 2'b00, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
